// File: rtl/axi4lite_cmd_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master command port among NUM_REQ requesters.
// One start pulse per grant; waits for done or a timeout, then acks the granted requester.
module axi4lite_cmd_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 16
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ-1:0]               req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
   output logic [NUM_REQ-1:0]               req_ack,
   output logic                             req_err,
   output logic [DATA_WIDTH-1:0]            req_rdata,
   output logic                             start_write,
   output logic                             start_read,
   output logic [ADDR_WIDTH-1:0]            write_addr,
   output logic [ADDR_WIDTH-1:0]            read_addr,
   output logic [DATA_WIDTH-1:0]            write_data,
   input  logic                             done,
   input  logic [DATA_WIDTH-1:0]            read_data,
   output logic                             busy,
   output logic [$clog2(NUM_REQ)-1:0]       grant_id
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t                  state_q;
   logic [ID_W-1:0]         grant_q;
   logic [ID_W-1:0]         last_grant_q;
   logic                    wr_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic [CNT_W-1:0]        cnt_q;
   logic                    start_wr_q;
   logic                    start_rd_q;
   logic                    err_q;
   logic                    busy_q;
   logic [NUM_REQ-1:0]      ack_q;

   logic                    found_d;
   logic [ID_W-1:0]         sel_d;
   logic [NUM_REQ-1:0]      grant_onehot;

   // Requester index k positions after base, wrapping at NUM_REQ (which need not be a power of two).
   function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return ID_W'(s);
   endfunction

   always_comb begin
      found_d = 1'b0;
      sel_d   = last_grant_q;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!found_d && req_valid[rr_idx(last_grant_q, k)]) begin
            found_d = 1'b1;
            sel_d   = rr_idx(last_grant_q, k);
         end
      end
   end

   assign grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         grant_q      <= '0;
         last_grant_q <= ID_W'(NUM_REQ-1);
         wr_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         cnt_q        <= '0;
         start_wr_q   <= 1'b0;
         start_rd_q   <= 1'b0;
         err_q        <= 1'b0;
         busy_q       <= 1'b0;
         ack_q        <= '0;
      end else begin
         start_wr_q <= 1'b0;
         start_rd_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (found_d) begin
                  grant_q    <= sel_d;
                  wr_q       <= req_write[sel_d];
                  addr_q     <= req_addr[sel_d*ADDR_WIDTH +: ADDR_WIDTH];
                  wdata_q    <= req_wdata[sel_d*DATA_WIDTH +: DATA_WIDTH];
                  start_wr_q <= req_write[sel_d];
                  start_rd_q <= !req_write[sel_d];
                  busy_q     <= 1'b1;
                  state_q    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               cnt_q   <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               // done is checked first so it wins on the final allowed cycle.
               if (done) begin
                  if (!wr_q) rdata_q <= read_data;
                  err_q   <= 1'b0;
                  ack_q   <= grant_onehot;
                  state_q <= S_RESP;
               end else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
                  err_q   <= 1'b1;
                  ack_q   <= grant_onehot;
                  state_q <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_RESP: begin
               ack_q        <= '0;
               err_q        <= 1'b0;
               last_grant_q <= grant_q;
               busy_q       <= 1'b0;
               state_q      <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ack     = ack_q;
   assign req_err     = err_q;
   assign req_rdata   = rdata_q;
   assign start_write = start_wr_q;
   assign start_read  = start_rd_q;
   assign write_addr  = addr_q;
   assign read_addr   = addr_q;
   assign write_data  = wdata_q;
   assign busy        = busy_q;
   assign grant_id    = grant_q;

endmodule

// File: tb/tb_axi4lite_cmd_arbiter.sv
// Bench for axi4lite_cmd_arbiter: directed requests, a master responder with programmable
// done delay, and start/ack monitors that compare against expected-transaction queues.
module tb_axi4lite_cmd_arbiter;

   localparam int NUM_REQ = 4;
   localparam int AW      = 2;
   localparam int DW      = 8;
   localparam int TIMEOUT = 16;
   localparam int ID_W    = 2;

   logic                   clk;
   logic                   rst_n = 1'b1;
   logic [NUM_REQ-1:0]     req_valid = '0;
   logic [NUM_REQ-1:0]     req_write = '0;
   logic [NUM_REQ*AW-1:0]  req_addr  = '0;
   logic [NUM_REQ*DW-1:0]  req_wdata = '0;
   logic [NUM_REQ-1:0]     req_ack;
   logic                   req_err;
   logic [DW-1:0]          req_rdata;
   logic                   start_write;
   logic                   start_read;
   logic [AW-1:0]          write_addr;
   logic [AW-1:0]          read_addr;
   logic [DW-1:0]          write_data;
   logic                   done;
   logic [DW-1:0]          read_data;
   logic                   busy;
   logic [ID_W-1:0]        grant_id;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic            wr;
      logic [AW-1:0]   addr;
      logic [DW-1:0]   data;
   } start_t;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic            err;
      logic [DW-1:0]   rdata;
      logic [7:0]      lat;
   } ack_t;

   start_t        exp_start_q[$];
   ack_t          exp_ack_q[$];
   int            n_chk = 0;
   int            n_pass = 0;
   int            cyc = 0;
   int            start_cyc = 0;
   int            mst_delay = 1;
   logic [DW-1:0] exp_rdata = '0;

   axi4lite_cmd_arbiter #(
      .NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ack(req_ack), .req_err(req_err), .req_rdata(req_rdata),
      .start_write(start_write), .start_read(start_read),
      .write_addr(write_addr), .read_addr(read_addr), .write_data(write_data),
      .done(done), .read_data(read_data), .busy(busy), .grant_id(grant_id)
   );

   // Master-side register contents returned on reads.
   function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
      case (a)
         2'd0:    return 8'hA5;
         2'd1:    return 8'h3C;
         2'd2:    return 8'h04;
         default: return 8'hE7;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin : cycle_counter
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      #2;
      check("rst_busy",   32'(busy),        32'd0);
      check("rst_ack",    32'(req_ack),     32'd0);
      check("rst_err",    32'(req_err),     32'd0);
      check("rst_rdata",  32'(req_rdata),   32'd0);
      check("rst_starts", 32'({start_write, start_read}), 32'd0);
      check("rst_waddr",  32'(write_addr),  32'd0);
      check("rst_raddr",  32'(read_addr),   32'd0);
      check("rst_wdata",  32'(write_data),  32'd0);
      check("rst_grant",  32'(grant_id),    32'd0);
      exp_rdata = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_req(input int id, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_write[id]         = wr;
      req_addr[id*AW +: AW] = a;
      req_wdata[id*DW +: DW] = d;
   endtask

   task automatic expect_txn(input int id, input logic wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input bit with_ack);
      start_t s;
      ack_t   k;
      s.id   = ID_W'(id);
      s.wr   = wr;
      s.addr = a;
      s.data = d;
      exp_start_q.push_back(s);
      if (with_ack) begin
         if (!wr && mst_delay != 0) exp_rdata = mem_val(a);
         k.id    = ID_W'(id);
         k.err   = (mst_delay == 0);
         k.rdata = exp_rdata;
         k.lat   = (mst_delay == 0) ? 8'(TIMEOUT + 1) : 8'(mst_delay + 1);
         exp_ack_q.push_back(k);
      end
   endtask

   // Requesters drop req_valid on the edge that samples their ack.
   task automatic wait_acks(input int n, input int budget);
      int got;
      int waited;
      logic [NUM_REQ-1:0] a;
      got    = 0;
      waited = 0;
      while (got < n && waited < budget) begin
         @(negedge clk);
         waited++;
         if (req_ack != '0) begin
            a = req_ack;
            @(posedge clk);
            #1 req_valid = req_valid & ~a;
            got++;
         end
      end
      check("ack_count", 32'(got), 32'(n));
   endtask

   // ---------------- master responder ----------------
   initial begin : responder
      int j;
      logic [AW-1:0] a;
      done      = 1'b0;
      read_data = '1;
      forever begin
         @(negedge clk);
         if (start_write || start_read) begin
            j = mst_delay;
            a = read_addr;
            if (j > 0) begin
               repeat (j) @(posedge clk);
               #1;
               done      = 1'b1;
               read_data = mem_val(a);
               @(posedge clk);
               #1;
               done      = 1'b0;
               read_data = '1;
            end
         end
      end
   end

   // ---------------- scoreboard monitors ----------------
   initial begin : mon_start
      start_t e;
      forever begin
         @(negedge clk);
         if (start_write || start_read) begin
            start_cyc = cyc;
            if (exp_start_q.size() == 0) begin
               check("unexpected_start", 32'({start_write, start_read}), 32'd0);
            end else begin
               e = exp_start_q.pop_front();
               check("start_kind", 32'({start_write, start_read}), e.wr ? 32'd2 : 32'd1);
               check("start_grant_id", 32'(grant_id), 32'(e.id));
               if (e.wr) begin
                  check("write_addr", 32'(write_addr), 32'(e.addr));
                  check("write_data", 32'(write_data), 32'(e.data));
               end else begin
                  check("read_addr", 32'(read_addr), 32'(e.addr));
               end
            end
         end
      end
   end

   initial begin : mon_ack
      ack_t e;
      forever begin
         @(negedge clk);
         if (req_ack != '0) begin
            if (exp_ack_q.size() == 0) begin
               check("unexpected_ack", 32'(req_ack), 32'd0);
            end else begin
               e = exp_ack_q.pop_front();
               check("ack_onehot", 32'(req_ack), 32'd1 << e.id);
               check("ack_err",    32'(req_err), 32'(e.err));
               check("ack_rdata",  32'(req_rdata), 32'(e.rdata));
               check("ack_latency", 32'(cyc - start_cyc), 32'(e.lat));
               check("ack_busy",   32'(busy), 32'd1);
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin : main
      #1;
      do_reset();

      // Write from requester 0, done in the third WAIT cycle.
      mst_delay = 3;
      set_req(0, 1'b1, 2'd2, 8'h04);
      expect_txn(0, 1'b1, 2'd2, 8'h04, 1'b1);
      req_valid = 4'b0001;
      wait_acks(1, 60);

      // Read from requester 1; result must persist afterwards.
      set_req(1, 1'b0, 2'd2, 8'h5A);
      expect_txn(1, 1'b0, 2'd2, 8'h5A, 1'b1);
      req_valid = 4'b0010;
      wait_acks(1, 60);
      repeat (3) @(posedge clk);
      #1;
      check("rdata_hold", 32'(req_rdata), 32'h04);
      check("idle_busy",  32'(busy), 32'd0);

      // Fairness from a fresh pointer: 0,1,2,3 then 0,3.
      do_reset();
      mst_delay = 1;
      set_req(0, 1'b1, 2'd1, 8'h11);
      set_req(1, 1'b0, 2'd3, 8'h00);
      set_req(2, 1'b1, 2'd0, 8'h22);
      set_req(3, 1'b0, 2'd1, 8'h00);
      expect_txn(0, 1'b1, 2'd1, 8'h11, 1'b1);
      expect_txn(1, 1'b0, 2'd3, 8'h00, 1'b1);
      expect_txn(2, 1'b1, 2'd0, 8'h22, 1'b1);
      expect_txn(3, 1'b0, 2'd1, 8'h00, 1'b1);
      req_valid = 4'b1111;
      wait_acks(4, 200);

      mst_delay = 2;
      set_req(0, 1'b1, 2'd2, 8'h55);
      set_req(3, 1'b0, 2'd0, 8'h00);
      expect_txn(0, 1'b1, 2'd2, 8'h55, 1'b1);
      expect_txn(3, 1'b0, 2'd0, 8'h00, 1'b1);
      req_valid = 4'b1001;
      wait_acks(2, 100);

      // Timeout: no done at all.
      mst_delay = 0;
      set_req(2, 1'b0, 2'd3, 8'h00);
      expect_txn(2, 1'b0, 2'd3, 8'h00, 1'b1);
      req_valid = 4'b0100;
      wait_acks(1, 60);

      // done in the last allowed WAIT cycle succeeds.
      mst_delay = TIMEOUT;
      set_req(1, 1'b0, 2'd1, 8'h00);
      expect_txn(1, 1'b0, 2'd1, 8'h00, 1'b1);
      req_valid = 4'b0010;
      wait_acks(1, 60);

      // Reset while WAITing, then requester 2 alone, then 0 and 2 together.
      mst_delay = 0;
      set_req(1, 1'b0, 2'd2, 8'h00);
      expect_txn(1, 1'b0, 2'd2, 8'h00, 1'b0);
      req_valid = 4'b0010;
      repeat (5) @(posedge clk);
      #1;
      check("mid_wait_busy", 32'(busy), 32'd1);
      do_reset();

      mst_delay = 1;
      set_req(2, 1'b1, 2'd3, 8'h99);
      expect_txn(2, 1'b1, 2'd3, 8'h99, 1'b1);
      req_valid = 4'b0100;
      wait_acks(1, 60);

      mst_delay = 3;
      set_req(0, 1'b0, 2'd2, 8'h00);
      set_req(2, 1'b0, 2'd1, 8'h00);
      expect_txn(0, 1'b0, 2'd2, 8'h00, 1'b1);
      expect_txn(2, 1'b0, 2'd1, 8'h00, 1'b1);
      req_valid = 4'b0101;
      wait_acks(2, 100);

      repeat (3) @(posedge clk);
      #1;
      check("start_q_drained", 32'(exp_start_q.size()), 32'd0);
      check("ack_q_drained",   32'(exp_ack_q.size()),   32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
